// File: rtl/pwm_pkg.sv
// Shared types for the PWM dead-band generator.
// Per-channel FSM state encoding and brake synchronizer depth.
package pwm_pkg;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        LOW  = 3'd1,
        DT_R = 3'd2,
        HIGH = 3'd3,
        DT_F = 3'd4
    } db_state_t;

    localparam int BRK_SYNC_W = 2;

endpackage

// File: rtl/pwm_db_ch.sv
// One dead-band channel: complementary H/L drive with dead time.
// Outputs are registered from the next state, so H and L never overlap.
module pwm_db_ch
    import pwm_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [DT_W-1:0] dead,
    input  logic            pwm_q,
    input  logic            pwm_d,
    output logic            pwm_h,
    output logic            pwm_l
);

    db_state_t       state;
    db_state_t       state_nxt;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_nxt;
    logic            h_nxt;
    logic            l_nxt;
    logic            rise;
    logic            fall;
    logic            dead_zero;
    logic            cnt_last;

    assign rise      = pwm_q & ~pwm_d;
    assign fall      = ~pwm_q & pwm_d;
    assign dead_zero = (dead == '0);
    assign cnt_last  = (cnt <= DT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OFF;
            cnt   <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pwm_h <= h_nxt;
            pwm_l <= l_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!en) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                OFF: begin
                    if (!pwm_q) begin
                        state_nxt = LOW;
                    end else begin
                        state_nxt = dead_zero ? HIGH : DT_R;
                        cnt_nxt   = dead;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_nxt = dead_zero ? HIGH : DT_R;
                        cnt_nxt   = dead;
                    end
                end
                DT_R: begin
                    if (fall) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt_last) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_nxt = dead_zero ? LOW : DT_F;
                        cnt_nxt   = dead;
                    end
                end
                DT_F: begin
                    if (rise) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt_last) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - DT_W'(1);
                    end
                end
                default: begin
                    state_nxt = OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        h_nxt = 1'b0;
        l_nxt = 1'b0;
        unique case (1'b1)
            (state_nxt == HIGH): h_nxt = 1'b1;
            (state_nxt == LOW):  l_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pwm_deadband.sv
// Multi-channel PWM dead-band inserter.
// Optional fault brake enabled by defining PWM_DB_BRAKE_EN.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int DT_W   = 8
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_en,
    input  logic [DT_W-1:0]   I_dead,
    input  logic [CH_NUM-1:0] I_pwm,
`ifdef PWM_DB_BRAKE_EN
    input  logic              I_brake,
    input  logic              I_brake_clr,
    output logic              O_brake_flag,
`endif
    output logic [CH_NUM-1:0] O_pwm_h,
    output logic [CH_NUM-1:0] O_pwm_l
);

    logic [CH_NUM-1:0] pwm_q;
    logic [CH_NUM-1:0] pwm_d;
    logic              run;

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            pwm_q <= '0;
            pwm_d <= '0;
        end else begin
            pwm_q <= I_pwm;
            pwm_d <= pwm_q;
        end
    end

`ifdef PWM_DB_BRAKE_EN
    logic [BRK_SYNC_W-1:0] brk_sync;
    logic                  brk_s;

    assign brk_s = brk_sync[BRK_SYNC_W-1];

    // Flag is sticky: set wins over clear while the fault persists
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            brk_sync     <= '0;
            O_brake_flag <= 1'b0;
        end else begin
            brk_sync <= {brk_sync[BRK_SYNC_W-2:0], I_brake};
            if (brk_s) begin
                O_brake_flag <= 1'b1;
            end else if (I_brake_clr) begin
                O_brake_flag <= 1'b0;
            end
        end
    end

    assign run = I_en & ~brk_s & ~O_brake_flag;
`else
    assign run = I_en;
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        pwm_db_ch #(
            .DT_W (DT_W)
        ) u_ch (
            .clk   (I_clk),
            .rst_n (I_rst_n),
            .en    (run),
            .dead  (I_dead),
            .pwm_q (pwm_q[g]),
            .pwm_d (pwm_d[g]),
            .pwm_h (O_pwm_h[g]),
            .pwm_l (O_pwm_l[g])
        );
    end

endmodule

// File: tb/tb_pwm_deadband.sv
// Bench for pwm_deadband: directed scenarios plus random traffic
// checked against a run-length / last-driven-side reference model.
module tb_pwm_deadband;

    localparam int CH = 8;
    localparam int DW = 8;

    logic          I_clk = 1'b0;
    logic          I_rst_n;
    logic          I_en;
    logic [DW-1:0] I_dead;
    logic [CH-1:0] I_pwm;
    logic [CH-1:0] O_pwm_h;
    logic [CH-1:0] O_pwm_l;
`ifdef PWM_DB_BRAKE_EN
    logic          I_brake;
    logic          I_brake_clr;
    logic          O_brake_flag;
`endif

    pwm_deadband #(
        .CH_NUM (CH),
        .DT_W   (DW)
    ) dut (
        .I_clk        (I_clk),
        .I_rst_n      (I_rst_n),
        .I_en         (I_en),
        .I_dead       (I_dead),
        .I_pwm        (I_pwm),
`ifdef PWM_DB_BRAKE_EN
        .I_brake      (I_brake),
        .I_brake_clr  (I_brake_clr),
        .O_brake_flag (O_brake_flag),
`endif
        .O_pwm_h      (O_pwm_h),
        .O_pwm_l      (O_pwm_l)
    );

    always #5 I_clk = ~I_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: side 0=none 1=low 2=high; gs/gd = start cycle and dead
    // time of the current input run (or of re-enable)
    logic [CH-1:0] m_pq  = '0;
    logic [CH-1:0] m_pqd = '0;
    logic          m_dis_prev = 1'b1;
    int            m_side [CH];
    int            m_gs   [CH];
    int            m_gd   [CH];
    logic [CH-1:0] exp_h;
    logic [CH-1:0] exp_l;
`ifdef PWM_DB_BRAKE_EN
    logic          m_s1   = 1'b0;
    logic          m_s2   = 1'b0;
    logic          m_flag = 1'b0;
`endif

    task automatic chk(input string tag, input logic [CH-1:0] obs,
                       input logic [CH-1:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, want);
        end
    endtask

    task automatic model_update();
        logic dis;
        logic w;
        int   ws;
        dis = !I_rst_n || !I_en;
`ifdef PWM_DB_BRAKE_EN
        dis = dis || m_s2 || m_flag;
`endif
        exp_h = '0;
        exp_l = '0;
        for (int c = 0; c < CH; c++) begin
            if (dis) begin
                m_side[c] = 0;
            end else begin
                w  = m_pq[c];
                ws = w ? 2 : 1;
                if (m_dis_prev || (m_pq[c] != m_pqd[c])) begin
                    m_gs[c] = cyc;
                    m_gd[c] = int'(I_dead);
                end
                if (m_side[c] == ws || (m_side[c] == 0 && !w) ||
                    cyc + 1 >= m_gs[c] + 1 + m_gd[c]) begin
                    m_side[c] = ws;
                    if (w) exp_h[c] = 1'b1;
                    else   exp_l[c] = 1'b1;
                end
            end
        end
`ifdef PWM_DB_BRAKE_EN
        if (!I_rst_n) begin
            m_flag = 1'b0;
            m_s2   = 1'b0;
            m_s1   = 1'b0;
        end else begin
            m_flag = m_s2 | (m_flag & ~I_brake_clr);
            m_s2   = m_s1;
            m_s1   = I_brake;
        end
`endif
        m_dis_prev = dis;
        m_pqd      = m_pq;
        m_pq       = I_rst_n ? I_pwm : '0;
    endtask

    task automatic step(input logic r, input logic e,
                        input logic [DW-1:0] d, input logic [CH-1:0] p);
        I_rst_n = r;
        I_en    = e;
        I_dead  = d;
        I_pwm   = p;
        model_update();
        @(posedge I_clk);
        #1;
        cyc++;
        chk("h", O_pwm_h, exp_h);
        chk("l", O_pwm_l, exp_l);
        chk("overlap", O_pwm_h & O_pwm_l, '0);
`ifdef PWM_DB_BRAKE_EN
        chk("flag", {{(CH-1){1'b0}}, O_brake_flag}, {{(CH-1){1'b0}}, m_flag});
`endif
    endtask

    initial begin
        logic [CH-1:0] p;
        logic [DW-1:0] d;
        logic          en;
        logic          rn;
        for (int c = 0; c < CH; c++) begin
            m_side[c] = 0;
            m_gs[c]   = 0;
            m_gd[c]   = 0;
        end
`ifdef PWM_DB_BRAKE_EN
        I_brake     = 1'b0;
        I_brake_clr = 1'b0;
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, '0);
        chk("rst_h", O_pwm_h, '0);
        chk("rst_l", O_pwm_l, '0);

        // Dead time 4 on a rising edge of channel 0
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'd4, '0);
        step(1'b1, 1'b1, 8'd4, 8'h01);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b1, 8'd4, 8'h01);
            chk("dt4_h", O_pwm_h & 8'h01, (k == 5) ? 8'h01 : 8'h00);
            chk("dt4_l", O_pwm_l & 8'h01, 8'h00);
        end

        // Short high pulse on channel 1 shorter than dead time 5
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd5, 8'h03);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'd5, 8'h01);
            chk("pulse_h", O_pwm_h & 8'h02, 8'h00);
        end
        chk("pulse_l", O_pwm_l & 8'h02, 8'h02);

        // Zero dead time square wave on channel 2
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 8'd0, ((i % 10) < 5) ? 8'h05 : 8'h01);

        // Dead time changes 8 -> 2 while a count is running
        step(1'b1, 1'b1, 8'd8, 8'h09);
        step(1'b1, 1'b1, 8'd8, 8'h09);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'd2, 8'h09);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'd2, 8'h01);

        // Enable drop during HIGH, re-enable with input high
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'd3, 8'h11);
        step(1'b1, 1'b0, 8'd3, 8'h11);
        chk("en_off_h", O_pwm_h, '0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'd3, 8'h11);

        // Reset in the middle of a dead interval
        step(1'b1, 1'b1, 8'd6, 8'h10);
        step(1'b1, 1'b1, 8'd6, 8'h10);
        step(1'b0, 1'b1, 8'd6, 8'h10);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd6, 8'h10);

`ifdef PWM_DB_BRAKE_EN
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'd2, 8'hff);
        I_brake = 1'b1;
        step(1'b1, 1'b1, 8'd2, 8'hff);
        I_brake = 1'b0;
        step(1'b1, 1'b1, 8'd2, 8'hff);
        step(1'b1, 1'b1, 8'd2, 8'hff);
        chk("brk_h", O_pwm_h, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd2, 8'hff);
        I_brake_clr = 1'b1;
        step(1'b1, 1'b1, 8'd2, 8'hff);
        I_brake_clr = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'd2, 8'hff);
`endif

        // Random traffic
        p = I_pwm;
        d = 8'd3;
        for (int i = 0; i < 900; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) p[c] = ~p[c];
            if ($urandom_range(0, 15) == 0) d = DW'($urandom_range(0, 5));
            en = ($urandom_range(0, 79) != 0);
            rn = ($urandom_range(0, 299) != 0);
`ifdef PWM_DB_BRAKE_EN
            I_brake     = ($urandom_range(0, 149) == 0);
            I_brake_clr = ($urandom_range(0, 9) == 0);
`endif
            step(rn, en, d, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_deadband.md
PWM_DEADBAND -- requirements
Module: pwm_deadband

Interface
REQ-001 SHALL have parameter CH_NUM, default 8, number of PWM channels.
REQ-002 SHALL have parameter DT_W, default 8, width of the dead-time count.
REQ-003 SHALL have port I_clk  input  1  system clock (S_sys_clk_100m domain); one clock; reset is synchronous and active-low.
REQ-004 SHALL have port I_rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port I_en  input  1  global enable; 0 forces all channels OFF.
REQ-006 SHALL have port I_dead  input  DT_W  dead time in I_clk cycles.
REQ-007 SHALL have port I_pwm  input  CH_NUM  raw PWM from ahb_pwm pwmo, synchronous to I_clk.
REQ-008 SHALL have port O_pwm_h  output  CH_NUM  high-side drive.
REQ-009 SHALL have port O_pwm_l  output  CH_NUM  low-side drive.

Function
REQ-010 SHALL register I_pwm once (pwm_q); all edge detection SHALL use pwm_q versus its previous value.
REQ-011 SHALL run one independent FSM per channel with states OFF (H=0,L=0), LOW (H=0,L=1), DT_R (0,0), HIGH (1,0), DT_F (0,0).
REQ-012 SHALL drive O_pwm_h/O_pwm_l from registers decoded from next state; no combinational path from I_pwm to outputs.
REQ-013 OFF: if I_en=1, go to LOW when pwm_q=0, else to DT_R with count loaded from I_dead.
REQ-014 LOW: pwm_q rising -> DT_R, load count=I_dead; if I_dead=0 go directly to HIGH.
REQ-015 DT_R: decrement count each cycle; move to HIGH in the cycle count reaches 1, so both outputs are 0 for exactly I_dead cycles; pwm_q falling -> LOW immediately.
REQ-016 HIGH/DT_F: mirror of LOW/DT_R with edge polarity inverted.
REQ-017 I_dead SHALL be sampled only at DT entry; changes mid-count SHALL not affect the running count.
REQ-018 Latency: I_pwm edge at cycle n -> outputs both 0 at n+2; active side asserted at n+2+I_dead.
REQ-019 O_pwm_h and O_pwm_l of one channel SHALL never be 1 in the same cycle under any input, including I_dead=0.
REQ-020 I_en=0 SHALL force every FSM to OFF on the next edge, overriding all other events.

Reset
REQ-021 With I_rst_n=0 at a rising edge, all FSMs SHALL be OFF; O_pwm_h, O_pwm_l, pwm_q, and counts SHALL be 0.
REQ-022 Reset asserted mid-dead-time SHALL abort the count; no output SHALL pulse on release.

Configuration
REQ-023 Macro PWM_DB_BRAKE_EN defined: SHALL add input I_brake (async fault), input I_brake_clr, and output O_brake_flag.
REQ-024 With the macro, I_brake SHALL pass a 2-FF synchronizer; a synchronized 1 SHALL set O_brake_flag and force all channels OFF within 3 cycles of assertion.
REQ-025 With the macro, O_brake_flag SHALL hold until I_brake_clr=1 while the synchronized brake is 0; channels stay OFF while the flag is set.
REQ-026 Without the macro, brake ports and logic SHALL be absent; behaviour is as REQ-010..020.

Structure
REQ-027 State encoding enum (OFF, LOW, DT_R, HIGH, DT_F) SHALL live in shared package pwm_pkg.
REQ-028 The per-channel FSM plus counter SHALL be sub-module pwm_db_ch, instantiated CH_NUM times via generate.

Verification
REQ-029 I_dead=4, channel 0 low->high at cycle 10: both outputs 0 for cycles 12-15; H=1 from cycle 16.
REQ-030 I_dead=5, input high pulse of 3 cycles: H never asserts; L returns to 1 after the pulse; no overlap.
REQ-031 I_dead=0, 50% square wave period 10: H/L complementary with 2-cycle latency; H&L=0 every cycle.
REQ-032 I_dead changes 8->2 during DT_R count: current dead interval lasts 8; next edge uses 2.
REQ-033 I_en dropped during HIGH: both outputs 0 next cycle; re-enable with pwm_q=1 -> DT_R then HIGH after I_dead.
REQ-034 PWM_DB_BRAKE_EN: pulse I_brake during HIGH: all outputs 0 by 3 cycles, O_brake_flag=1; after I_brake_clr, channels resume via LOW/DT_R.
